sum_display: RTL and testbench

//  Downstream consumer of the 3-bit ripple adder: captures its 4-bit result {carry, sum[2:0]} on a

---
 rtl/sum_display_pkg.sv | 33 +++
 rtl/sum_display_seg7_dec.sv | 28 ++
 rtl/sum_display.sv | 146 ++++++++++++++
 tb/tb_sum_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum_display block.
//   state_e     : conversion FSM states
//   BcdW        : width of the two-nibble BCD accumulator
//   Seg0..Seg9  : active-low {g,f,e,d,c,b,a} patterns for the decimal digits
//   SegBlank    : all segments off
//   dabble_adj  : double-dabble correction applied to one BCD nibble before a shift
package sum_display_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StConv
  } state_e;

  localparam int unsigned BcdW = 8;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;

  // A nibble >= 5 would become >= 10 after doubling, so pre-add 3 to carry into the next digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/sum_display_seg7_dec.sv
// Combinational BCD to 7-segment decoder (common anode, active-low segments).
//   digit_i : 4-bit BCD digit
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low; codes above 9 show blank
module sum_display_seg7_dec
  import sum_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    case (digit_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/sum_display.sv
// Accepts an unsigned adder result on a valid/ready handshake, converts it to two BCD digits
// with a bit-serial double-dabble engine, and drives a 2-digit multiplexed common-anode
// 7-segment display that holds the last converted value.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   sum_valid : upstream result valid
//   sum_in    : adder result {Co, S}, unsigned
//   sum_ready : high while idle (able to accept)
//   done      : one-cycle pulse when new digits are latched
//   seg       : segments {g,f,e,d,c,b,a}, active-low, registered
//   an        : digit anodes, active-low, registered; an[0] = units, an[1] = tens
module sum_display
  import sum_display_pkg::*;
#(
  parameter int unsigned IN_W        = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sum_valid,
  input  logic [IN_W-1:0] sum_in,
  output logic            sum_ready,
  output logic            done,
  output logic [6:0]      seg,
  output logic [1:0]      an
);

  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        units_q, units_d;
  logic [3:0]        tens_q, tens_d;
  logic              done_q, done_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;
  logic [3:0]        digit_mux;
  logic [6:0]        dec_seg;

  // One double-dabble step: correct both nibbles, then shift the next binary MSB in.
  assign bcd_adj   = {dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
  assign bcd_shift = BcdW'({bcd_adj, bin_q[IN_W-1]});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      units_q <= '0;
      tens_q  <= '0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      sel_q   <= 1'b0;
      seg_q   <= Seg0;
      an_q    <= 2'b10;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Next state: FSM and conversion datapath
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    tens_d  = tens_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sum_valid) begin
          bin_d   = sum_in;
          bcd_d   = '0;
          cnt_d   = CntW'(IN_W);
          state_d = StConv;
        end
      end
      StConv: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - CntW'(1);
        // Last shift: latch the finished digits straight from the shifter output.
        if (cnt_q == CntW'(1)) begin
          units_d = bcd_shift[3:0];
          tens_d  = bcd_shift[7:4];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next state: display refresh and registered segment/anode drive
  always_comb begin
    ref_d = ref_q + RefW'(1);
    sel_d = sel_q;
    if (ref_q == RefLast) begin
      ref_d = '0;
      sel_d = ~sel_q;
    end
    digit_mux = sel_q ? tens_q : units_q;
    seg_d     = dec_seg;
    if (sel_q && BLANK_LZ && (tens_q == 4'd0)) begin
      seg_d = SegBlank;
    end
    an_d = sel_q ? 2'b01 : 2'b10;
  end

  sum_display_seg7_dec u_dec (
    .digit_i (digit_mux),
    .seg_o   (dec_seg)
  );

  // Outputs
  always_comb begin
    sum_ready = (state_q == StIdle);
    done      = done_q;
    seg       = seg_q;
    an        = an_q;
  end

endmodule

// File: tb/tb_sum_display.sv
// Scoreboard bench for sum_display: stimulus pushes expected digits and done cycle, a
// negedge monitor checks done timing and every displayed slot against the expected digits.
module tb_sum_display;

  localparam int unsigned InW = 4;
  localparam int unsigned Div = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sum_valid = 1'b0;
  logic [InW-1:0] sum_in = '0;
  logic           sum_ready;
  logic           done;
  logic [6:0]     seg;
  logic [1:0]     an;

  sum_display #(
    .IN_W        (InW),
    .REFRESH_DIV (Div),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_valid (sum_valid),
    .sum_in    (sum_in),
    .sum_ready (sum_ready),
    .done      (done),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [3:0]  units;
    logic [3:0]  tens;
    int unsigned done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [3:0] cur_u = '0, cur_t = '0, shown_u = '0, shown_t = '0;
  bit         mon_en = 1'b0;
  logic [1:0] last_an = 2'b10;
  int         run_len = 0;
  bit         first_run = 1'b1;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cycle, act, exp);
    end
  endtask

  // Monitor: seg/an lag the digit registers by one cycle, so check against 'shown'.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (an == 2'b10) begin
        check("seg_units", {25'd0, seg}, {25'd0, seg_of(shown_u)});
      end else if (an == 2'b01) begin
        check("seg_tens", {25'd0, seg},
              {25'd0, (shown_t == 4'd0) ? 7'b1111111 : seg_of(shown_t)});
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL an_onehot at cycle %0d: got %b, want 10 or 01", cycle, an);
      end
      if (an == last_an) begin
        run_len++;
      end else begin
        if (!first_run) check("an_period", run_len, Div);
        first_run = 1'b0;
        run_len   = 1;
        last_an   = an;
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_pulse at cycle %0d: got unexpected done, want none", cycle);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_checks--;
          check("done_latency", cycle, e.done_cyc);
          cur_u = e.units;
          cur_t = e.tens;
        end
      end
      shown_u = cur_u;
      shown_t = cur_t;
    end
  end

  // Present v until accepted; optionally keep valid high with a new value afterwards.
  task automatic send(input logic [3:0] v, input logic [3:0] eu, input logic [3:0] et,
                      input bit hold, input logic [3:0] nxt, output int unsigned acc);
    bit rdy;
    bit ok;
    exp_t e;
    ok        = 1'b0;
    acc       = 0;
    sum_in    = v;
    sum_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = sum_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc        = cycle;
        e.units    = eu;
        e.tens     = et;
        e.done_cyc = acc + InW;
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: value %0d not accepted, want accept within 50 cycles", v);
    end
    if (hold) sum_in = nxt;
    else sum_valid = 1'b0;
  endtask

  // Wait for the scoreboard to drain, then long enough for both slots to refresh.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: %0d results pending, want 0", exp_q.size());
    end
    repeat (2 * Div + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned acc1, acc2, dummy;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", sum_ready, 1);
    check("rst_done", done, 0);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, 7'b1000000);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2 * Div + 2) @(posedge clk);
    #1;

    // 7+7 = 14 -> "14"
    send(4'b1110, 4'd4, 4'd1, 1'b0, 4'd0, dummy);
    wait_idle();
    // 15 -> "15", then 0 -> tens blank
    send(4'b1111, 4'd5, 4'd1, 1'b0, 4'd0, dummy);
    wait_idle();
    send(4'b0000, 4'd0, 4'd0, 1'b0, 4'd0, dummy);
    wait_idle();
    send(4'd7, 4'd7, 4'd0, 1'b0, 4'd0, dummy);
    wait_idle();
    send(4'd10, 4'd0, 4'd1, 1'b0, 4'd0, dummy);
    wait_idle();

    // Valid held through CONV with 3: ignored until the cycle after done
    send(4'd14, 4'd4, 4'd1, 1'b1, 4'd3, acc1);
    send(4'd3, 4'd3, 4'd0, 1'b0, 4'd0, acc2);
    check("b2b_accept", acc2, acc1 + InW + 1);
    wait_idle();
    send(4'd13, 4'd3, 4'd1, 1'b0, 4'd0, dummy);
    wait_idle();

    // 16 refresh periods of idle display
    repeat (16 * Div) @(posedge clk);
    #1;

    // Async reset 2 cycles into converting 9
    send(4'd9, 4'd9, 4'd0, 1'b0, 4'd0, dummy);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    cur_u   = '0;
    cur_t   = '0;
    shown_u = '0;
    shown_t = '0;
    #1;
    check("arst_ready", sum_ready, 1);
    check("arst_done", done, 0);
    check("arst_an", an, 2'b10);
    check("arst_seg", seg, 7'b1000000);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    first_run = 1'b1;
    last_an   = 2'b10;
    run_len   = 0;
    mon_en    = 1'b1;
    repeat (4 * Div + 8) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
